// File: rtl/avalon_master_pkg.sv
// Shared types and defaults for the Avalon-MM command master and its command FIFO.
package avalon_master_pkg;

    localparam int unsigned DATA_W                 = 32;
    localparam int unsigned ADDR_W                 = 1;
    localparam int unsigned TIMER_W                = 8;
    localparam int unsigned DEFAULT_FIFO_DEPTH     = 4;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/avalon_master_if.sv
// Command, response and Avalon-MM signals of the master, bundled for port connection.
interface avalon_master_if;
    import avalon_master_pkg::*;

    logic              cmdValid;
    logic              cmdReady;
    logic              cmdWrite;
    logic [ADDR_W-1:0] cmdAddress;
    logic [DATA_W-1:0] cmdData;
    logic              rspValid;
    logic [DATA_W-1:0] rspData;
    logic              rspError;
    logic              avRead;
    logic              avWrite;
    logic [ADDR_W-1:0] avAddress;
    logic [DATA_W-1:0] avWriteData;
    logic [DATA_W-1:0] avReadData;
    logic              avReadValid;
    logic              busy;

    modport master (
        input  cmdValid, cmdWrite, cmdAddress, cmdData, avReadData, avReadValid,
        output cmdReady, rspValid, rspData, rspError, avRead, avWrite, avAddress,
               avWriteData, busy
    );

    modport slave (
        output cmdValid, cmdWrite, cmdAddress, cmdData, avReadData, avReadValid,
        input  cmdReady, rspValid, rspData, rspError, avRead, avWrite, avAddress,
               avWriteData, busy
    );

endinterface

// File: rtl/avalon_cmd_fifo.sv
// Synchronous FIFO of command records; head is shown combinationally (first-word fall-through).
module avalon_cmd_fifo
    import avalon_master_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  cmd_t             push_cmd,
    input  logic             pop,
    output cmd_t             head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_cmd;
    end

endmodule

// File: rtl/avalon_master.sv
// Queues read/write commands and plays them one at a time onto an Avalon-MM slave,
// returning read data (or a timeout error) as a single-cycle response pulse.
module avalon_master
    import avalon_master_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    avalon_master_if.master bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t             state, state_n;
    logic [TIMER_W-1:0] timer, timer_n;

    logic              av_read_q, av_read_n;
    logic              av_write_q, av_write_n;
    logic [ADDR_W-1:0] av_address_q, av_address_n;
    logic [DATA_W-1:0] av_write_data_q, av_write_data_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_n;
    logic              rsp_error_q, rsp_error_n;

    cmd_t             push_cmd;
    cmd_t             head;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;

    assign push_cmd = '{write: bus.cmdWrite, address: bus.cmdAddress, data: bus.cmdData};
    assign push     = bus.cmdValid && !full;

    assign bus.cmdReady    = !full;
    assign bus.busy        = (state != ST_IDLE) || (count != '0);
    assign bus.avRead      = av_read_q;
    assign bus.avWrite     = av_write_q;
    assign bus.avAddress   = av_address_q;
    assign bus.avWriteData = av_write_data_q;
    assign bus.rspValid    = rsp_valid_q;
    assign bus.rspData     = rsp_data_q;
    assign bus.rspError    = rsp_error_q;

    avalon_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (push),
        .push_cmd (push_cmd),
        .pop      (pop),
        .head     (head),
        .full     (full),
        .empty    (empty),
        .count    (count)
    );

    // State, timer and every registered output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            timer           <= '0;
            av_read_q       <= 1'b0;
            av_write_q      <= 1'b0;
            av_address_q    <= '0;
            av_write_data_q <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_data_q      <= '0;
            rsp_error_q     <= 1'b0;
        end else begin
            state           <= state_n;
            timer           <= timer_n;
            av_read_q       <= av_read_n;
            av_write_q      <= av_write_n;
            av_address_q    <= av_address_n;
            av_write_data_q <= av_write_data_n;
            rsp_valid_q     <= rsp_valid_n;
            rsp_data_q      <= rsp_data_n;
            rsp_error_q     <= rsp_error_n;
        end
    end

    // Output registers are loaded with the values belonging to the next state,
    // so strobes line up with ISSUE and rspValid with RESP.
    always_comb begin
        state_n         = state;
        timer_n         = timer;
        pop             = 1'b0;
        av_read_n       = 1'b0;
        av_write_n      = 1'b0;
        av_address_n    = av_address_q;
        av_write_data_n = av_write_data_q;
        rsp_valid_n     = 1'b0;
        rsp_data_n      = rsp_data_q;
        rsp_error_n     = rsp_error_q;

        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop             = 1'b1;
                    av_address_n    = head.address;
                    av_write_data_n = head.data;
                    av_write_n      = head.write;
                    av_read_n       = !head.write;
                    state_n         = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_n = '0;
                state_n = av_write_q ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                // Valid data takes priority over a coincident timeout.
                if (bus.avReadValid) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = bus.avReadData;
                    rsp_error_n = 1'b0;
                    state_n     = ST_RESP;
                end else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                    rsp_valid_n = 1'b1;
                    rsp_data_n  = '0;
                    rsp_error_n = 1'b1;
                    state_n     = ST_RESP;
                end else begin
                    timer_n = timer + TIMER_W'(1);
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/avalon_master.md
AVALON_MASTER -- requirements
Module: avalon_master

Interface
REQ-001 FIFO_DEPTH, 4, command FIFO entries; power of two, 2..16.
REQ-002 TIMEOUT_CYCLES, 16, maximum WAIT cycles for avReadValid before error; 1..255.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 cmdValid  in  1  command offered.
REQ-006 cmdReady  out  1  command FIFO not full.
REQ-007 cmdWrite  in  1  1 = write, 0 = read.
REQ-008 cmdAddress  in  1  peripheral register address.
REQ-009 cmdData  in  32  write data; ignored for reads.
REQ-010 rspValid  out  1  one-cycle read-response pulse, no backpressure.
REQ-011 rspData  out  32  read data, valid with rspValid.
REQ-012 rspError  out  1  read timed out, valid with rspValid.
REQ-013 avRead  out  1  Avalon read strobe.
REQ-014 avWrite  out  1  Avalon write strobe.
REQ-015 avAddress  out  1  Avalon address.
REQ-016 avWriteData  out  32  Avalon write data.
REQ-017 avReadData  in  32  Avalon read data.
REQ-018 avReadValid  in  1  Avalon read data valid; peripheral asserts it 1 cycle after avRead.
REQ-019 busy  out  1  FSM not IDLE or FIFO not empty.

Function
REQ-020 Command accepted on rising edge with cmdValid && cmdReady; {cmdWrite, cmdAddress, cmdData} pushed in order.
REQ-021 cmdReady = !full, combinational from FIFO count only; a pop in the same cycle does not raise it.
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE: FIFO non-empty -> pop head, register avAddress/avWriteData, go ISSUE; else stay.
REQ-024 ISSUE: exactly one cycle; avWrite=cmdWrite, avRead=!cmdWrite; write -> IDLE, read -> WAIT with timer cleared.
REQ-025 avRead and avWrite never both 1; each high for exactly one cycle per command.
REQ-026 WAIT: avReadValid=1 -> capture avReadData, rspError=0, go RESP.
REQ-027 WAIT: timer increments each cycle without avReadValid; when timer reaches TIMEOUT_CYCLES -> rspData=0, rspError=1, go RESP.
REQ-028 avReadValid and timer expiry in the same cycle: valid data wins, rspError=0.
REQ-029 RESP: rspValid=1 for one cycle, then IDLE.
REQ-030 avReadValid outside WAIT ignored; no response generated.
REQ-031 Writes produce no response.
REQ-032 Minimum read latency: command accepted at edge N -> avRead high in cycle N+2 -> rspValid high in cycle N+4.
REQ-033 Throughput: one write per 2 cycles; one read per 4 cycles at minimum slave latency.
REQ-034 At most one read outstanding at any time.
REQ-035 FIFO read/write pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH.
REQ-036 rspData and rspError hold their values until the next RESP.
REQ-037 avAddress and avWriteData hold their values after ISSUE until the next pop.

Reset
REQ-038 Reset asynchronously forces state IDLE, FIFO empty, timer 0.
REQ-039 Reset values: cmdReady=1 after release, rspValid=0, rspData=0, rspError=0, avRead=0, avWrite=0, avAddress=0, avWriteData=0, busy=0.
REQ-040 Reset mid-read discards the transaction; no rspValid after release for that read.

Structure
REQ-041 Package avalon_master_pkg holds the state enum, the command struct {write, address, data}, and default FIFO_DEPTH and TIMEOUT_CYCLES.
REQ-042 One sub-module, avalon_cmd_fifo: synchronous FIFO of command structs with full/empty/count.
REQ-043 All outputs are registered except cmdReady and busy.

Verification
REQ-044 Write addr0 0xDEADBEEF -> avWrite=1, avAddress=0, avWriteData=0xDEADBEEF for exactly one cycle, two cycles after acceptance; no rspValid.
REQ-045 Read addr1, slave returns 0x12345678 one cycle later -> rspValid pulse with rspData=0x12345678 and rspError=0 in cycle N+4.
REQ-046 Read with avReadValid held low -> rspValid after 16 WAIT cycles with rspError=1 and rspData=0; next queued command then issues.
REQ-047 Push 5 commands back-to-back with FIFO_DEPTH=4 while a read is stalled -> cmdReady=0 after the 4th push; all 4 commands issue in order.
REQ-048 Assert reset during WAIT -> all outputs go to reset values immediately; no rspValid after release; a new command runs normally.
REQ-049 Stray avReadValid pulse while IDLE -> no rspValid; rspData unchanged.
